// File: rtl/jtag_dtm_pkg.sv
// Shared types and constants for the JTAG debug transport module.
package jtag_dtm_pkg;

   // IEEE 1149.1 TAP controller states
   typedef enum logic [3:0] {
      TAP_RESET,
      TAP_IDLE,
      TAP_SEL_DR,
      TAP_CAP_DR,
      TAP_SHIFT_DR,
      TAP_EXIT1_DR,
      TAP_PAUSE_DR,
      TAP_EXIT2_DR,
      TAP_UPD_DR,
      TAP_SEL_IR,
      TAP_CAP_IR,
      TAP_SHIFT_IR,
      TAP_EXIT1_IR,
      TAP_PAUSE_IR,
      TAP_EXIT2_IR,
      TAP_UPD_IR
   } tap_state_t;

   // Data register selected by the current instruction
   typedef enum logic [1:0] {
      DR_BYPASS,
      DR_IDCODE,
      DR_DTMCS,
      DR_DMI
   } dr_sel_t;

   // Instruction codes
   localparam logic [4:0] IR_IDCODE  = 5'h01;
   localparam logic [4:0] IR_DTMCS   = 5'h10;
   localparam logic [4:0] IR_DMI     = 5'h11;
   localparam logic [4:0] IR_BYPASS  = 5'h1f;
   localparam logic [4:0] IR_CAPTURE = 5'b00001;

   // DMI request ops
   localparam logic [1:0] DMI_OP_NOP   = 2'd0;
   localparam logic [1:0] DMI_OP_READ  = 2'd1;
   localparam logic [1:0] DMI_OP_WRITE = 2'd2;

   // DMI sticky status / captured op values
   localparam logic [1:0] DMI_STAT_OK     = 2'd0;
   localparam logic [1:0] DMI_STAT_FAILED = 2'd2;
   localparam logic [1:0] DMI_STAT_BUSY   = 2'd3;

   // DTMCS field offsets and fixed field values
   localparam int DTMCS_VERSION_LSB   = 0;
   localparam int DTMCS_ABITS_LSB     = 4;
   localparam int DTMCS_DMISTAT_LSB   = 10;
   localparam int DTMCS_IDLE_LSB      = 12;
   localparam int DTMCS_DMIRESET_BIT  = 16;
   localparam int DTMCS_HARDRESET_BIT = 17;
   localparam logic [3:0] DTMCS_VERSION = 4'd1;
   localparam logic [2:0] DTMCS_IDLE    = 3'd1;

   // Read value of DTMCS for a given address width and sticky status
   function automatic logic [31:0] dtmcs_value(input logic [5:0] abits,
                                               input logic [1:0] dmistat);
      logic [31:0] v;
      v = '0;
      v[DTMCS_VERSION_LSB +: 4] = DTMCS_VERSION;
      v[DTMCS_ABITS_LSB +: 6]   = abits;
      v[DTMCS_DMISTAT_LSB +: 2] = dmistat;
      v[DTMCS_IDLE_LSB +: 3]    = DTMCS_IDLE;
      return v;
   endfunction

endpackage

// File: rtl/jtag_pin_sync.sv
// Brings the asynchronous JTAG pins into the clk domain and derives
// single-cycle TCK rise/fall events.
module jtag_pin_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic tck_i,
   input  logic tms_i,
   input  logic tdi_i,
   output logic tms,
   output logic tdi,
   output logic tck_rise,
   output logic tck_fall
);

   // {tck, tms, tdi} per stage; all three pins see identical latency
   logic [2:0] sync_q [SYNC_STAGES];
   logic       tck_hist;
   logic       tck_s;

   // synchronizer chain
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= {tck_i, tms_i, tdi_i};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   // history flop on the synchronized tck for edge detection
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) tck_hist <= 1'b0;
      else          tck_hist <= tck_s;
   end

   assign tck_s    = sync_q[SYNC_STAGES-1][2];
   assign tms      = sync_q[SYNC_STAGES-1][1];
   assign tdi      = sync_q[SYNC_STAGES-1][0];
   assign tck_rise = tck_s & ~tck_hist;
   assign tck_fall = ~tck_s & tck_hist;

endmodule

// File: rtl/jtag_dtm_tap.sv
// RISC-V debug transport module: JTAG TAP with IDCODE/DTMCS/DMI/BYPASS
// registers, turning DMI scans into request/response transactions.
module jtag_dtm_tap
   import jtag_dtm_pkg::*;
#(
   parameter logic [31:0] IDCODE      = 32'h1000_0001,
   parameter int          ABITS       = 7,
   parameter int          SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             tck_i,
   input  logic             tms_i,
   input  logic             tdi_i,
   output logic             tdo_o,
   output logic             dmi_req_valid,
   input  logic             dmi_req_ready,
   output logic [ABITS-1:0] dmi_req_addr,
   output logic [31:0]      dmi_req_data,
   output logic [1:0]       dmi_req_op,
   input  logic             dmi_resp_valid,
   input  logic [31:0]      dmi_resp_data,
   input  logic [1:0]       dmi_resp_op
);

   localparam int DW = ABITS + 34;

   logic          tms, tdi, tck_rise, tck_fall;
   tap_state_t    state, state_next;
   logic          capture_dr, shift_dr, update_dr;
   logic          capture_ir, shift_ir, update_ir;
   logic [4:0]    ir, ir_shift;
   logic [DW-1:0] dr_shift;
   dr_sel_t       dr_sel;
   logic [1:0]    dmi_stat, stat_eff, cap_op;
   logic          busy, busy_eff;
   logic [31:0]   resp_data;
   logic [1:0]    upd_op;

   jtag_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pin_sync (
      .clk      (clk),
      .reset_n  (reset_n),
      .tck_i    (tck_i),
      .tms_i    (tms_i),
      .tdi_i    (tdi_i),
      .tms      (tms),
      .tdi      (tdi),
      .tck_rise (tck_rise),
      .tck_fall (tck_fall)
   );

   // TAP state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= TAP_RESET;
      else          state <= state_next;
   end

   // TAP next state, plus one-cycle action strobes for the state being left
   always_comb begin
      state_next = state;
      capture_dr = 1'b0;
      shift_dr   = 1'b0;
      update_dr  = 1'b0;
      capture_ir = 1'b0;
      shift_ir   = 1'b0;
      update_ir  = 1'b0;
      if (tck_rise) begin
         case (state)
            TAP_RESET:    state_next = tms ? TAP_RESET    : TAP_IDLE;
            TAP_IDLE:     state_next = tms ? TAP_SEL_DR   : TAP_IDLE;
            TAP_SEL_DR:   state_next = tms ? TAP_SEL_IR   : TAP_CAP_DR;
            TAP_CAP_DR:   state_next = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_SHIFT_DR: state_next = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_EXIT1_DR: state_next = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
            TAP_PAUSE_DR: state_next = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
            TAP_EXIT2_DR: state_next = tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
            TAP_UPD_DR:   state_next = tms ? TAP_SEL_DR   : TAP_IDLE;
            TAP_SEL_IR:   state_next = tms ? TAP_RESET    : TAP_CAP_IR;
            TAP_CAP_IR:   state_next = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_SHIFT_IR: state_next = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_EXIT1_IR: state_next = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
            TAP_PAUSE_IR: state_next = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
            TAP_EXIT2_IR: state_next = tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
            TAP_UPD_IR:   state_next = tms ? TAP_SEL_DR   : TAP_IDLE;
            default:      state_next = TAP_RESET;
         endcase
         capture_dr = (state == TAP_CAP_DR);
         shift_dr   = (state == TAP_SHIFT_DR);
         update_dr  = (state == TAP_UPD_DR);
         capture_ir = (state == TAP_CAP_IR);
         shift_ir   = (state == TAP_SHIFT_IR);
         update_ir  = (state == TAP_UPD_IR);
      end
   end

   // instruction decode; unknown codes fall back to BYPASS
   always_comb begin
      dr_sel = DR_BYPASS;
      case (ir)
         IR_IDCODE: dr_sel = DR_IDCODE;
         IR_DTMCS:  dr_sel = DR_DTMCS;
         IR_DMI:    dr_sel = DR_DMI;
         IR_BYPASS: dr_sel = DR_BYPASS;
         default:   dr_sel = DR_BYPASS;
      endcase
   end

   // IR shift chain and instruction register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ir       <= IR_IDCODE;
         ir_shift <= '0;
      end else begin
         if (capture_ir)    ir_shift <= IR_CAPTURE;
         else if (shift_ir) ir_shift <= {tdi, ir_shift[4:1]};
         if (state == TAP_RESET) ir <= IR_IDCODE;
         else if (update_ir)     ir <= ir_shift;
      end
   end

   // DR shift chain; TDI enters at the MSB of the selected register's length
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dr_shift <= '0;
      end else if (capture_dr) begin
         case (dr_sel)
            DR_IDCODE: dr_shift <= {{(DW-32){1'b0}}, IDCODE};
            DR_DTMCS:  dr_shift <= {{(DW-32){1'b0}}, dtmcs_value(6'(ABITS), dmi_stat)};
            DR_DMI:    dr_shift <= {dmi_req_addr, resp_data, cap_op};
            default:   dr_shift <= '0;
         endcase
      end else if (shift_dr) begin
         case (dr_sel)
            DR_IDCODE, DR_DTMCS: dr_shift <= {{(DW-32){1'b0}}, tdi, dr_shift[31:1]};
            DR_DMI:              dr_shift <= {tdi, dr_shift[DW-1:1]};
            default:             dr_shift <= {{(DW-1){1'b0}}, tdi};
         endcase
      end
   end

   // TDO updates on falling TCK and is quiet outside the shift states
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tdo_o <= 1'b0;
      end else if (tck_fall) begin
         if (state == TAP_SHIFT_IR)      tdo_o <= ir_shift[0];
         else if (state == TAP_SHIFT_DR) tdo_o <= dr_shift[0];
         else                            tdo_o <= 1'b0;
      end
   end

   // a response arriving with an Update-DR is applied before the update
   always_comb begin
      busy_eff = busy & ~dmi_resp_valid;
      stat_eff = (dmi_resp_valid && dmi_resp_op == DMI_STAT_FAILED) ? DMI_STAT_FAILED : dmi_stat;
      cap_op   = (dmi_stat != DMI_STAT_OK) ? dmi_stat :
                 (busy ? DMI_STAT_BUSY : DMI_STAT_OK);
      upd_op   = dr_shift[1:0];
   end

   // DMI request/response handling and DTMCS side effects
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dmi_req_valid <= 1'b0;
         dmi_req_addr  <= '0;
         dmi_req_data  <= '0;
         dmi_req_op    <= DMI_OP_NOP;
         dmi_stat      <= DMI_STAT_OK;
         busy          <= 1'b0;
         resp_data     <= '0;
      end else begin
         if (dmi_req_valid && dmi_req_ready) dmi_req_valid <= 1'b0;
         if (dmi_resp_valid) resp_data <= dmi_resp_data;
         busy     <= busy_eff;
         dmi_stat <= stat_eff;
         if (update_dr && dr_sel == DR_DTMCS) begin
            if (dr_shift[DTMCS_DMIRESET_BIT] || dr_shift[DTMCS_HARDRESET_BIT])
               dmi_stat <= DMI_STAT_OK;
            if (dr_shift[DTMCS_HARDRESET_BIT]) begin
               busy          <= 1'b0;
               dmi_req_valid <= 1'b0;
            end
         end
         if (update_dr && dr_sel == DR_DMI && stat_eff == DMI_STAT_OK) begin
            if (busy_eff) begin
               dmi_stat <= DMI_STAT_BUSY;
            end else if (upd_op == DMI_OP_READ || upd_op == DMI_OP_WRITE) begin
               dmi_req_valid <= 1'b1;
               dmi_req_addr  <= dr_shift[DW-1:34];
               dmi_req_data  <= dr_shift[33:2];
               dmi_req_op    <= upd_op;
               busy          <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_jtag_dtm_tap.sv
// Self-checking bench for jtag_dtm_tap: directed scans followed by random
// DMI/DTMCS/BYPASS traffic checked against a transaction-level model.
module tb_jtag_dtm_tap;

   localparam int          ABITS  = 7;
   localparam int          DW     = ABITS + 34;
   localparam logic [31:0] IDCODE = 32'h1000_0001;
   localparam int          HALF   = 5;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             tck_i = 1'b0;
   logic             tms_i = 1'b1;
   logic             tdi_i = 1'b0;
   logic             tdo_o;
   logic             dmi_req_valid;
   logic             dmi_req_ready = 1'b0;
   logic [ABITS-1:0] dmi_req_addr;
   logic [31:0]      dmi_req_data;
   logic [1:0]       dmi_req_op;
   logic             dmi_resp_valid = 1'b0;
   logic [31:0]      dmi_resp_data = '0;
   logic [1:0]       dmi_resp_op = '0;

   int checks = 0;
   int errors = 0;
   int txn = 0;

   // reference model state
   logic [1:0]       m_stat = 2'd0;
   logic             m_busy = 1'b0;
   logic [ABITS-1:0] m_addr = '0;
   logic [31:0]      m_data = '0;
   logic [4:0]       cur_ir = 5'h01;

   jtag_dtm_tap #(.IDCODE(IDCODE), .ABITS(ABITS), .SYNC_STAGES(2)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .tck_i          (tck_i),
      .tms_i          (tms_i),
      .tdi_i          (tdi_i),
      .tdo_o          (tdo_o),
      .dmi_req_valid  (dmi_req_valid),
      .dmi_req_ready  (dmi_req_ready),
      .dmi_req_addr   (dmi_req_addr),
      .dmi_req_data   (dmi_req_data),
      .dmi_req_op     (dmi_req_op),
      .dmi_resp_valid (dmi_resp_valid),
      .dmi_resp_data  (dmi_resp_data),
      .dmi_resp_op    (dmi_resp_op)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [1:0] model_cap_op();
      if (m_stat != 2'd0) return m_stat;
      if (m_busy) return 2'd3;
      return 2'd0;
   endfunction

   // one full TCK period: low phase (TDO sampled at its end), then high phase
   task automatic tck_cycle(input logic tms_v, input logic tdi_v, output logic tdo_v);
      tck_i = 1'b0;
      tms_i = tms_v;
      tdi_i = tdi_v;
      repeat (HALF) @(posedge clk);
      #1;
      tdo_v = tdo_o;
      tck_i = 1'b1;
      repeat (HALF) @(posedge clk);
      #1;
   endtask

   // Idle -> Shift-IR -> shift code -> Update-IR -> Idle
   task automatic scan_ir(input logic [4:0] code);
      logic       o;
      logic [4:0] cap;
      tck_cycle(1'b1, 1'b0, o);
      tck_cycle(1'b1, 1'b0, o);
      tck_cycle(1'b0, 1'b0, o);
      tck_cycle(1'b0, 1'b0, o);
      for (int i = 0; i < 5; i++) begin
         tck_cycle(i == 4, code[i], o);
         cap[i] = o;
      end
      tck_cycle(1'b1, 1'b0, o);
      tck_cycle(1'b0, 1'b0, o);
      check_val("ir_capture", 64'(cap), 64'(5'b00001));
      cur_ir = code;
   endtask

   // Idle -> Shift-DR -> shift n bits -> Update-DR -> Idle
   task automatic scan_dr(input int n, input logic [63:0] din, output logic [63:0] dout);
      logic o;
      dout = '0;
      tck_cycle(1'b1, 1'b0, o);
      tck_cycle(1'b0, 1'b0, o);
      tck_cycle(1'b0, 1'b0, o);
      for (int i = 0; i < n; i++) begin
         tck_cycle(i == n - 1, din[i], o);
         dout[i] = o;
      end
      tck_cycle(1'b1, 1'b0, o);
      tck_cycle(1'b0, 1'b0, o);
      check_val("tdo_idle", 64'(tdo_o), 64'd0);
   endtask

   task automatic handshake(input int k, input logic [ABITS-1:0] a, input logic [31:0] d,
                            input logic [1:0] op);
      for (int i = 0; i < k; i++) begin
         @(posedge clk);
         #1;
         check_val("req_hold_valid", 64'(dmi_req_valid), 64'd1);
         check_val("req_hold_payload", {dmi_req_addr, dmi_req_data, dmi_req_op},
                   {a, d, op});
      end
      dmi_req_ready = 1'b1;
      @(posedge clk);
      #1;
      dmi_req_ready = 1'b0;
      check_val("req_drop", 64'(dmi_req_valid), 64'd0);
   endtask

   // k < 0 leaves an issued request pending
   task automatic dmi_scan(input logic [1:0] op, input logic [ABITS-1:0] a, input logic [31:0] d,
                           input int k);
      logic [63:0] din, dout, exp;
      logic        issue;
      if (cur_ir != 5'h11) scan_ir(5'h11);
      din = 64'({a, d, op});
      exp = 64'({m_addr, m_data, model_cap_op()});
      scan_dr(DW, din, dout);
      check_val("dmi_capture", dout, exp);
      issue = 1'b0;
      if (m_stat != 2'd0) issue = 1'b0;
      else if (m_busy) m_stat = 2'd3;
      else if (op == 2'd1 || op == 2'd2) issue = 1'b1;
      check_val("req_valid", 64'(dmi_req_valid), 64'(issue));
      if (issue) begin
         check_val("req_addr", 64'(dmi_req_addr), 64'(a));
         check_val("req_data", 64'(dmi_req_data), 64'(d));
         check_val("req_op", 64'(dmi_req_op), 64'(op));
         m_addr = a;
         m_busy = 1'b1;
         if (k >= 0) handshake(k, a, d, op);
      end
      txn++;
      $display("txn %0d dmi op=%0d addr=0x%0h data=0x%08h captured=0x%0h issued=%0d",
               txn, op, a, d, dout, issue);
   endtask

   task automatic send_resp(input logic [31:0] d, input logic [1:0] op);
      dmi_resp_valid = 1'b1;
      dmi_resp_data  = d;
      dmi_resp_op    = op;
      @(posedge clk);
      #1;
      dmi_resp_valid = 1'b0;
      m_busy = 1'b0;
      m_data = d;
      if (op == 2'd2) m_stat = 2'd2;
      txn++;
      $display("txn %0d resp data=0x%08h op=%0d", txn, d, op);
   endtask

   task automatic dtmcs_scan(input logic [31:0] din);
      logic [63:0] dout;
      if (cur_ir != 5'h10) scan_ir(5'h10);
      scan_dr(32, 64'(din), dout);
      check_val("dtmcs_capture", dout, 64'(32'h0000_1071 | (32'(m_stat) << 10)));
      if (din[17]) begin
         m_stat = 2'd0;
         m_busy = 1'b0;
         check_val("hardreset_valid", 64'(dmi_req_valid), 64'd0);
      end
      if (din[16]) m_stat = 2'd0;
      txn++;
      $display("txn %0d dtmcs write=0x%08h captured=0x%08h", txn, din, dout[31:0]);
   endtask

   task automatic bypass_scan(input logic [7:0] v, input logic [4:0] code);
      logic [63:0] dout;
      if (cur_ir != code) scan_ir(code);
      scan_dr(9, 64'(v), dout);
      check_val("bypass_stream", dout, 64'(v) << 1);
      txn++;
      $display("txn %0d bypass ir=0x%0h in=0x%02h out=0x%03h", txn, code, v, dout[8:0]);
   endtask

   initial begin
      logic [63:0] dout;
      logic        o;
      int          r;

      // reset state
      repeat (4) @(posedge clk);
      #1;
      check_val("rst_tdo", 64'(tdo_o), 64'd0);
      check_val("rst_valid", 64'(dmi_req_valid), 64'd0);
      check_val("rst_payload", {dmi_req_addr, dmi_req_data, dmi_req_op}, 64'd0);
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // five TMS=1 then Idle, IDCODE scan
      for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, o);
      tck_cycle(1'b0, 1'b0, o);
      scan_dr(32, 64'd0, dout);
      check_val("idcode", dout, 64'(IDCODE));

      // directed sequence
      bypass_scan(8'hA5, 5'h1F);
      dtmcs_scan(32'h0);
      dmi_scan(2'd2, 7'h10, 32'h0000_0001, 3);
      send_resp(32'hCAFE_F00D, 2'd0);
      dmi_scan(2'd1, 7'h22, 32'h0, 1);
      dmi_scan(2'd2, 7'h33, 32'h5, 0);
      dmi_scan(2'd0, 7'h0, 32'h0, 0);
      send_resp(32'h1234_5678, 2'd0);
      dtmcs_scan(32'h0001_0000);
      dmi_scan(2'd2, 7'h44, 32'hDEAD_BEEF, 2);
      send_resp(32'h0BAD_0BAD, 2'd2);
      dmi_scan(2'd1, 7'h55, 32'h0, 0);
      dtmcs_scan(32'h0001_0000);

      // random traffic
      for (int it = 0; it < 24; it++) begin
         r = $urandom_range(0, 9);
         if (r < 5)
            dmi_scan(2'($urandom_range(0, 2)), 7'($urandom), $urandom, $urandom_range(0, 3));
         else if (r < 7 && m_busy)
            send_resp($urandom, ($urandom_range(0, 3) == 0) ? 2'd2 : 2'd0);
         else if (r < 9)
            dtmcs_scan({14'($urandom), ($urandom_range(0, 5) == 0), 1'($urandom), 16'($urandom)});
         else
            bypass_scan(8'($urandom), ($urandom_range(0, 1) == 1) ? 5'h1F : 5'h0A);
      end

      // five TMS=1 from Shift-IR reach Test-Logic-Reset and restore IDCODE
      tck_cycle(1'b1, 1'b0, o);
      tck_cycle(1'b1, 1'b0, o);
      tck_cycle(1'b0, 1'b0, o);
      tck_cycle(1'b0, 1'b0, o);
      tck_cycle(1'b0, 1'($urandom), o);
      tck_cycle(1'b0, 1'($urandom), o);
      for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, o);
      tck_cycle(1'b0, 1'b0, o);
      cur_ir = 5'h01;
      scan_dr(32, 64'($urandom), dout);
      check_val("tlr_idcode", dout, 64'(IDCODE));

      // reset in the middle of Shift-DR with a request pending
      dtmcs_scan(32'h0003_0000);
      dmi_scan(2'd2, 7'h3C, $urandom, -1);
      tck_cycle(1'b1, 1'b0, o);
      tck_cycle(1'b0, 1'b0, o);
      tck_cycle(1'b0, 1'b0, o);
      for (int i = 0; i < 4; i++) tck_cycle(1'b0, 1'b1, o);
      check_val("pending_valid", 64'(dmi_req_valid), 64'd1);
      tms_i = 1'b1;
      reset_n = 1'b0;
      #1;
      check_val("midrst_valid", 64'(dmi_req_valid), 64'd0);
      check_val("midrst_tdo", 64'(tdo_o), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      m_stat = 2'd0;
      m_busy = 1'b0;
      m_addr = '0;
      m_data = '0;
      cur_ir = 5'h01;
      repeat (2 * HALF) @(posedge clk);
      #1;
      tck_cycle(1'b0, 1'b0, o);
      scan_dr(32, 64'd0, dout);
      check_val("postrst_idcode", dout, 64'(IDCODE));
      dmi_scan(2'd0, 7'h0, 32'h0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
